// File: rtl/sat_pkg.sv
// sat_pkg -- shared definitions for the saturation block.
//   CLIP_CNT_W : width of the optional clip counter.
//   clip_e     : classification of one sample (no clip / positive / negative).
//   sat_max()  : largest value of an osz-bit two's complement word.
//   sat_min()  : smallest value of an osz-bit two's complement word.
package sat_pkg;

  localparam int unsigned CLIP_CNT_W = 16;

  typedef enum logic [1:0] {
    CLIP_NONE = 2'd0,
    CLIP_POS  = 2'd1,
    CLIP_NEG  = 2'd2
  } clip_e;

  function automatic int sat_max(input int osz);
    return (1 << (osz - 1)) - 1;
  endfunction

  function automatic int sat_min(input int osz);
    return -(1 << (osz - 1));
  endfunction

endpackage

// File: rtl/sat_core.sv
// sat_core -- combinational clip logic, ISZ-bit signed in to OSZ-bit signed out.
// Parameters: ISZ (input width), OSZ (output width), ISZ >= OSZ >= 2.
// Ports:
//   in  [ISZ-1:0] signed sample
//   out [OSZ-1:0] saturated sample
//   pos           sample clipped at the positive limit
//   neg           sample clipped at the negative limit
module sat_core
  import sat_pkg::*;
#(
  parameter int ISZ = 15,
  parameter int OSZ = 14
) (
  input  logic [ISZ-1:0] in,
  output logic [OSZ-1:0] out,
  output logic           pos,
  output logic           neg
);

  localparam logic [OSZ-1:0] MAX_W = OSZ'(sat_max(OSZ));
  localparam logic [OSZ-1:0] MIN_W = OSZ'(sat_min(OSZ));

  generate
    if (ISZ == OSZ) begin : g_pass
      // Same width: the value always fits.
      always_comb begin
        out = in;
        pos = 1'b0;
        neg = 1'b0;
      end
    end else begin : g_clip
      logic [ISZ-OSZ:0] top;
      clip_e            kind;

      // The value fits iff every bit from the output sign bit upward
      // is a copy of the input sign bit.
      assign top = in[ISZ-1:OSZ-1];

      always_comb begin
        kind = CLIP_NONE;
        if (!((&top) || (~|top))) begin
          kind = in[ISZ-1] ? CLIP_NEG : CLIP_POS;
        end
      end

      always_comb begin
        out = in[OSZ-1:0];
        pos = 1'b0;
        neg = 1'b0;
        case (kind)
          CLIP_POS: begin
            out = MAX_W;
            pos = 1'b1;
          end
          CLIP_NEG: begin
            out = MIN_W;
            neg = 1'b1;
          end
          default: ;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/sat.sv
// sat -- registered two's complement saturator, latency 1 clock.
// Optional feature macro: SAT_STATS_EN (adds stats_clr / clip_cnt).
// Parameters: ISZ (input width, default 15), OSZ (output width, default 14).
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   qualifies in
//   in         ISZ-bit signed sample
//   out_valid  registered in_valid
//   out        OSZ-bit saturated sample, holds when in_valid = 0
//   sat_pos    clipped at positive limit (with out_valid)
//   sat_neg    clipped at negative limit (with out_valid)
//   stats_clr  synchronous clear of clip_cnt (SAT_STATS_EN only)
//   clip_cnt   saturating count of clipped valid samples (SAT_STATS_EN only)
module sat
  import sat_pkg::*;
#(
  parameter int ISZ = 15,
  parameter int OSZ = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [ISZ-1:0]        in,
  output logic                  out_valid,
  output logic [OSZ-1:0]        out,
  output logic                  sat_pos,
  output logic                  sat_neg
`ifdef SAT_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [CLIP_CNT_W-1:0] clip_cnt
`endif
);

  logic [OSZ-1:0] core_out;
  logic           core_pos;
  logic           core_neg;

  sat_core #(
    .ISZ (ISZ),
    .OSZ (OSZ)
  ) u_core (
    .in  (in),
    .out (core_out),
    .pos (core_pos),
    .neg (core_neg)
  );

  logic [OSZ-1:0] out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           sat_pos_q, sat_pos_d;
  logic           sat_neg_q, sat_neg_d;

  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    sat_pos_d   = in_valid & core_pos;
    sat_neg_d   = in_valid & core_neg;
    if (in_valid) begin
      out_d = core_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_pos_q   <= 1'b0;
      sat_neg_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_pos_q   <= sat_pos_d;
      sat_neg_q   <= sat_neg_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sat_pos   = sat_pos_q;
  assign sat_neg   = sat_neg_q;

`ifdef SAT_STATS_EN
  logic [CLIP_CNT_W-1:0] clip_cnt_q, clip_cnt_d;

  // Clear takes priority over a same-cycle clip; count sticks at all-ones.
  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (stats_clr) begin
      clip_cnt_d = '0;
    end else if (in_valid && (core_pos || core_neg) && (clip_cnt_q != '1)) begin
      clip_cnt_d = clip_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_sat.sv
// tb_sat -- self-checking bench for sat (ISZ=15/OSZ=14) plus an ISZ=OSZ=8 instance.
module tb_sat;

  localparam int MAX = 8191;
  localparam int MIN = -8192;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [14:0] in_s;
  logic        out_valid;
  logic [13:0] out_s;
  logic        sat_pos;
  logic        sat_neg;

  logic        in8_valid;
  logic [7:0]  in8;
  logic        out8_valid;
  logic [7:0]  out8;
  logic        pos8;
  logic        neg8;

`ifdef SAT_STATS_EN
  logic        stats_clr;
  logic [15:0] clip_cnt;
  int          m_cnt;
`endif

  int n_cmp;
  int n_err;
  int m_out;

  sat #(
    .ISZ (15),
    .OSZ (14)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in_s),
    .out_valid (out_valid),
    .out       (out_s),
    .sat_pos   (sat_pos),
    .sat_neg   (sat_neg)
`ifdef SAT_STATS_EN
    ,
    .stats_clr (stats_clr),
    .clip_cnt  (clip_cnt)
`endif
  );

  sat #(
    .ISZ (8),
    .OSZ (8)
  ) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in8_valid),
    .in        (in8),
    .out_valid (out8_valid),
    .out       (out8),
    .sat_pos   (pos8),
    .sat_neg   (neg8)
`ifdef SAT_STATS_EN
    ,
    .stats_clr (1'b0),
    .clip_cnt  ()
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One sample through the main instance: drive at negedge, compare at next negedge.
  task automatic step(input logic v, input int x, input logic clr);
    int e_out;
    int e_pos;
    int e_neg;
    in_valid = v;
    in_s     = 15'(x);
`ifdef SAT_STATS_EN
    stats_clr = clr;
`endif
    e_pos = 0;
    e_neg = 0;
    if (x > MAX) begin
      e_out = MAX;
      e_pos = 1;
    end else if (x < MIN) begin
      e_out = MIN;
      e_neg = 1;
    end else begin
      e_out = x;
    end
    if (!v) begin
      e_pos = 0;
      e_neg = 0;
    end else begin
      m_out = e_out;
    end
`ifdef SAT_STATS_EN
    if (clr) m_cnt = 0;
    else if ((e_pos + e_neg) != 0 && m_cnt < 65535) m_cnt++;
`else
    if (clr) e_out = e_out;
`endif
    @(posedge clk);
    @(negedge clk);
    check("out_valid", int'(out_valid), int'(v));
    check("out", int'($signed(out_s)), m_out);
    check("sat_pos", int'(sat_pos), e_pos);
    check("sat_neg", int'(sat_neg), e_neg);
`ifdef SAT_STATS_EN
    check("clip_cnt", int'(clip_cnt), m_cnt);
`endif
  endtask

  task automatic step8(input int x);
    in8_valid = 1'b1;
    in8       = 8'(x);
    @(posedge clk);
    @(negedge clk);
    in8_valid = 1'b0;
    check("out8", int'($signed(out8)), x);
    check("out8_valid", int'(out8_valid), 1);
    check("flags8", int'({pos8, neg8}), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, int'(out_s), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_flags"}, int'({sat_pos, sat_neg}), 0);
    check({tag, "_out8"}, int'(out8), 0);
`ifdef SAT_STATS_EN
    check({tag, "_cnt"}, int'(clip_cnt), 0);
`endif
  endtask

  int corner[10] = '{8191, 8192, 16383, -8192, -8193, -16384, 0, 1, -1, 9000};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m_out     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_s      = '0;
    in8_valid = 1'b0;
    in8       = '0;
`ifdef SAT_STATS_EN
    stats_clr = 1'b0;
    m_cnt     = 0;
`endif
    #1;
    check_reset_state("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_hold");
    reset = 1'b1;

    // Directed boundary values.
    step(1'b1, 8191, 1'b0);
    step(1'b1, 8192, 1'b0);
    step(1'b1, 16383, 1'b0);
    step(1'b1, -8192, 1'b0);
    step(1'b1, -8193, 1'b0);
    step(1'b1, -16384, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b1, -1, 1'b0);
    step(1'b0, 9000, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 9000, 1'b0);
    step(1'b1, -9000, 1'b0);

    // Randomised stream, mixing full-range and boundary values.
    for (int i = 0; i < 400; i++) begin
      int x;
      if ($urandom_range(0, 3) == 0) x = corner[$urandom_range(0, 9)];
      else x = int'($urandom_range(0, 32767)) - 16384;
      step(($urandom_range(0, 3) != 0), x, 1'b0);
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    in_valid = 1'b1;
    in_s     = 15'(16383);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("rst_mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_mid_hold");
    m_out = 0;
`ifdef SAT_STATS_EN
    m_cnt = 0;
`endif
    in_valid = 1'b0;
    reset    = 1'b1;
    step(1'b1, 100, 1'b0);

`ifdef SAT_STATS_EN
    step(1'b1, 9000, 1'b1);
    step(1'b1, 9000, 1'b0);
    step(1'b1, -9000, 1'b0);
    step(1'b1, 20, 1'b0);
    step(1'b1, 10000, 1'b0);
    check("cnt_three", int'(clip_cnt), 3);
    step(1'b1, -10000, 1'b1);
    check("cnt_clr_wins", int'(clip_cnt), 0);
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, (i % 2 == 0) ? 12000 : -12000, 1'b0);
    end
    check("cnt_saturate", int'(clip_cnt), 65535);
`endif

    // Equal-width instance: no clipping possible.
    step8(127);
    step8(-128);
    for (int i = 0; i < 20; i++) begin
      step8(int'($urandom_range(0, 255)) - 128);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sat.md
SAT -- requirements
Module: sat

Interface
REQ-001 Parameter ISZ, default 15, input word width in bits, two's complement; legal range ISZ >= OSZ >= 2.
REQ-002 Parameter OSZ, default 14, output word width in bits, two's complement.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  qualifies in for the current cycle.
REQ-006 in  input  ISZ  signed sample to be saturated.
REQ-007 out_valid  output  1  registered copy of in_valid.
REQ-008 out  output  OSZ  signed, saturated, registered sample.
REQ-009 sat_pos  output  1  high with out_valid when the sample clipped at the positive limit.
REQ-010 sat_neg  output  1  high with out_valid when the sample clipped at the negative limit.
REQ-011 stats_clr  input  1  synchronous clear of the clip counters; exists only with SAT_STATS_EN.
REQ-012 clip_cnt  output  16  unsigned count of clipped valid samples; exists only with SAT_STATS_EN.

Function
REQ-013 MAX = 2^(OSZ-1)-1 and MIN = -2^(OSZ-1).
REQ-014 Saturation rule: in > MAX -> MAX; in < MIN -> MIN; otherwise in[OSZ-1:0] unchanged.
REQ-015 Overflow detection: in[ISZ-1:OSZ-1] all equal -> no clip. Otherwise the sign bit in[ISZ-1] selects the limit: 0 -> MAX, 1 -> MIN.
REQ-016 ISZ == OSZ: no clip is possible; out = in and sat_pos/sat_neg stay 0.
REQ-017 Latency is exactly 1 clock: out, out_valid, sat_pos and sat_neg update on the edge after in is presented.
REQ-018 When in_valid = 0: out holds its previous value, out_valid = 0, sat_pos = sat_neg = 0.
REQ-019 sat_pos and sat_neg are mutually exclusive.
REQ-020 There is no back-pressure; one sample is accepted per cycle, back-to-back.

Reset
REQ-021 While reset = 0: out = 0, out_valid = 0, sat_pos = 0, sat_neg = 0, and clip_cnt = 0 (when present).
REQ-022 Reset asserts asynchronously. It releases synchronously to clk. An in-flight sample is discarded.
REQ-023 The first valid output appears 1 cycle after the first in_valid following reset release.

Configuration
REQ-024 Macro SAT_STATS_EN defined: stats_clr and clip_cnt exist.
- clip_cnt increments by 1 on each cycle where a valid sample clips (either limit).
- It saturates at 16'hFFFF and does not wrap.
- stats_clr = 1 forces clip_cnt to 0 on the next edge; clear wins over a simultaneous clip event.
REQ-025 Macro SAT_STATS_EN undefined: stats_clr and clip_cnt are absent, no counter logic is built, and all other behaviour is identical.

Structure
REQ-026 Shared package sat_pkg holds CLIP_CNT_W = 16 and the functions sat_max(OSZ) and sat_min(OSZ).
REQ-027 The combinational clip logic (REQ-014..016) lives in one sub-module, sat_core.
- Inputs: in. Outputs: saturated word, pos flag, neg flag.
- Parameters: ISZ, OSZ.
- sat instantiates sat_core and adds the registers and counter.

Verification (ISZ=15, OSZ=14, MAX=8191, MIN=-8192)
REQ-028 in = 8191, 8192 and 16383, each with in_valid = 1 -> out = 8191, 8191, 8191 one cycle later; sat_pos = 0, 1, 1 respectively.
REQ-029 in = -8192, -8193 and -16384 -> out = -8192 each; sat_neg = 0, 1, 1 respectively.
REQ-030 in = 0, 1 and -1 -> out = 0, 1, -1 with no flags; in_valid = 0 with in = 9000 -> out holds, out_valid = 0, no flags.
REQ-031 reset pulled low mid-stream with no clock edge -> all outputs are 0 immediately; after release, first valid in = 100 -> out = 100 on the next edge.
REQ-032 With SAT_STATS_EN:
- 3 clipping samples -> clip_cnt = 3.
- stats_clr together with a clipping sample -> clip_cnt = 0.
- 65540 clipping samples -> clip_cnt = 65535.
REQ-033 Parameter sweep ISZ = OSZ = 8: in = 127 -> out = 127, and in = -128 -> out = -128, with no flags.
